// File: rtl/alu_seq16.sv
// alu_seq16 -- 16-bit sequential ALU built around an external 4-bit ALU slice.
//
// An operation is accepted on a Start pulse, then processed one nibble per
// clock (least significant nibble first) by driving the external 4-bit ALU
// and capturing its output. The carry ripples between nibbles through an
// internal carry register. Four captures later the block signals Done for
// one cycle and presents Result, Cout and Zero.
//
// Ports:
//   Clk            rising-edge clock
//   Clr_n          asynchronous active-low reset
//   Start          request a new operation (ignored while busy)
//   Op[2:0]        operation code (ADD, ADC, SUB, SBC, AND, OR, NAND, PASSC)
//   Cin            carry-in used by ADC/SBC
//   Xa, Xb, Xc     16-bit operands (Xc is only used by PASSC)
//   Busy           high while nibbles are being processed
//   Done           one-cycle completion pulse
//   Result[15:0]   final result, held until the next operation overwrites it
//   Cout, Zero     final carry (no-borrow for subtraction) and zero flag
//   AluA/B/C[3:0]  nibble operands to the external ALU
//   AluAi, AluBi   operand inversion controls to the external ALU
//   AluKin         carry-in to the external ALU
//   AluM[1:0]      external ALU mode (00 NAND, 01 NOR, 10 SUM, 11 pass C)
//   AluOut[3:0]    nibble result from the external ALU
//   AluKout        carry-out from the external ALU

module alu_seq16 (
    input  logic        Clk,
    input  logic        Clr_n,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic        Cin,
    input  logic [15:0] Xa,
    input  logic [15:0] Xb,
    input  logic [15:0] Xc,
    output logic        Busy,
    output logic        Done,
    output logic [15:0] Result,
    output logic        Cout,
    output logic        Zero,
    output logic [3:0]  AluA,
    output logic [3:0]  AluB,
    output logic [3:0]  AluC,
    output logic        AluAi,
    output logic        AluBi,
    output logic        AluKin,
    output logic [1:0]  AluM,
    input  logic [3:0]  AluOut,
    input  logic        AluKout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  idx;
    logic        carry;
    logic [2:0]  op_q;
    logic        cin_q;
    logic [15:0] xa_q;
    logic [15:0] xb_q;
    logic [15:0] xc_q;

    logic [1:0]  dec_m;
    logic        dec_ai;
    logic        dec_bi;
    logic        dec_arith;
    logic        dec_kin0;
    logic [3:0]  nib_lsb;

    logic        accept;

    // Bit position of the nibble currently being processed.
    assign nib_lsb = {idx, 2'b00};

    // A new operation can be taken whenever we are not mid-calculation.
    assign accept = (state != RUN) && Start;

    // Decode the latched opcode into ALU controls. Subtraction is done as
    // A + ~B + carry, so SUB/SBC invert B and SUB forces the first carry to 1.
    // AND and OR are obtained from NOR/NAND with both operands inverted.
    always_comb begin
        dec_m     = 2'b00;
        dec_ai    = 1'b0;
        dec_bi    = 1'b0;
        dec_arith = 1'b0;
        dec_kin0  = 1'b0;
        case (op_q)
            3'b000: begin dec_m = 2'b10; dec_arith = 1'b1; end
            3'b001: begin dec_m = 2'b10; dec_arith = 1'b1; dec_kin0 = cin_q; end
            3'b010: begin dec_m = 2'b10; dec_arith = 1'b1; dec_bi = 1'b1; dec_kin0 = 1'b1; end
            3'b011: begin dec_m = 2'b10; dec_arith = 1'b1; dec_bi = 1'b1; dec_kin0 = cin_q; end
            3'b100: begin dec_m = 2'b01; dec_ai = 1'b1; dec_bi = 1'b1; end
            3'b101: begin dec_m = 2'b00; dec_ai = 1'b1; dec_bi = 1'b1; end
            3'b110: begin dec_m = 2'b00; end
            3'b111: begin dec_m = 2'b11; end
            default: begin dec_m = 2'b00; end
        endcase
    end

    // State register.
    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: DONE lasts a single cycle unless a new Start
    // arrives, which chains straight into the next operation.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (Start) state_next = RUN;
            RUN:  if (idx == 2'd3) state_next = DONE;
            DONE: state_next = Start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand latch and nibble datapath. Flags are only updated on the
    // final capture so they stay stable from the previous operation.
    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) begin
            idx    <= 2'd0;
            carry  <= 1'b0;
            op_q   <= 3'd0;
            cin_q  <= 1'b0;
            xa_q   <= 16'h0000;
            xb_q   <= 16'h0000;
            xc_q   <= 16'h0000;
            Result <= 16'h0000;
            Cout   <= 1'b0;
            Zero   <= 1'b0;
        end else if (accept) begin
            op_q  <= Op;
            cin_q <= Cin;
            xa_q  <= Xa;
            xb_q  <= Xb;
            xc_q  <= Xc;
            idx   <= 2'd0;
            carry <= 1'b0;
        end else if (state == RUN) begin
            Result[nib_lsb +: 4] <= AluOut;
            carry                <= AluKout;
            idx                  <= idx + 2'd1;
            if (idx == 2'd3) begin
                Cout <= dec_arith & AluKout;
                Zero <= ({AluOut, Result[11:0]} == 16'h0000);
            end
        end
    end

    // Status outputs and external ALU drive. Outside RUN the ALU inputs
    // are held at zero so the slice sees a quiet bus.
    always_comb begin
        Busy   = (state == RUN);
        Done   = (state == DONE);
        AluA   = 4'h0;
        AluB   = 4'h0;
        AluC   = 4'h0;
        AluAi  = 1'b0;
        AluBi  = 1'b0;
        AluKin = 1'b0;
        AluM   = 2'b00;
        if (state == RUN) begin
            AluA   = xa_q[nib_lsb +: 4];
            AluB   = xb_q[nib_lsb +: 4];
            AluC   = xc_q[nib_lsb +: 4];
            AluAi  = dec_ai;
            AluBi  = dec_bi;
            AluM   = dec_m;
            AluKin = dec_arith & ((idx == 2'd0) ? dec_kin0 : carry);
        end
    end

endmodule

// File: tb/tb_alu_seq16.sv
// tb_alu_seq16 -- self-checking bench for alu_seq16.
//
// Contains a behavioural model of the 4-bit ALU slice wired to the Alu*
// ports, and a whole-word reference model of each opcode used to predict
// Result/Cout/Zero. Each scenario lives in its own task.

module tb_alu_seq16;

    logic        Clk = 1'b0;
    logic        Clr_n;
    logic        Start;
    logic [2:0]  Op;
    logic        Cin;
    logic [15:0] Xa;
    logic [15:0] Xb;
    logic [15:0] Xc;
    logic        Busy;
    logic        Done;
    logic [15:0] Result;
    logic        Cout;
    logic        Zero;
    logic [3:0]  AluA;
    logic [3:0]  AluB;
    logic [3:0]  AluC;
    logic        AluAi;
    logic        AluBi;
    logic        AluKin;
    logic [1:0]  AluM;
    logic [3:0]  AluOut;
    logic        AluKout;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    alu_seq16 dut (
        .Clk     (Clk),
        .Clr_n   (Clr_n),
        .Start   (Start),
        .Op      (Op),
        .Cin     (Cin),
        .Xa      (Xa),
        .Xb      (Xb),
        .Xc      (Xc),
        .Busy    (Busy),
        .Done    (Done),
        .Result  (Result),
        .Cout    (Cout),
        .Zero    (Zero),
        .AluA    (AluA),
        .AluB    (AluB),
        .AluC    (AluC),
        .AluAi   (AluAi),
        .AluBi   (AluBi),
        .AluKin  (AluKin),
        .AluM    (AluM),
        .AluOut  (AluOut),
        .AluKout (AluKout)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // Behavioural 4-bit ALU slice.
    logic [3:0] alu_a_eff;
    logic [3:0] alu_b_eff;
    logic [4:0] alu_sum;
    always_comb begin
        alu_a_eff = AluA ^ {4{AluAi}};
        alu_b_eff = AluB ^ {4{AluBi}};
        alu_sum   = {1'b0, alu_a_eff} + {1'b0, alu_b_eff} + {4'b0000, AluKin};
        AluOut    = 4'h0;
        AluKout   = 1'b0;
        case (AluM)
            2'b00: AluOut = ~(alu_a_eff & alu_b_eff);
            2'b01: AluOut = ~(alu_a_eff | alu_b_eff);
            2'b10: begin AluOut = alu_sum[3:0]; AluKout = alu_sum[4]; end
            default: AluOut = AluC;
        endcase
    end

    // Whole-word reference: {carry/no-borrow, result}.
    function automatic logic [16:0] ref_op(input logic [2:0] op, input logic cin,
                                           input logic [15:0] a, input logic [15:0] b,
                                           input logic [15:0] c);
        logic [16:0] r;
        case (op)
            3'd0: r = {1'b0, a} + {1'b0, b};
            3'd1: r = {1'b0, a} + {1'b0, b} + {16'h0000, cin};
            3'd2: r = {1'b0, a} + {1'b0, ~b} + 17'd1;
            3'd3: r = {1'b0, a} + {1'b0, ~b} + {16'h0000, cin};
            3'd4: r = {1'b0, a & b};
            3'd5: r = {1'b0, a | b};
            3'd6: r = {1'b0, ~(a & b)};
            default: r = {1'b0, c};
        endcase
        return r;
    endfunction

    task automatic start_op(input logic [2:0] op, input logic cin,
                            input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        @(negedge Clk);
        Start = 1'b1;
        Op    = op;
        Cin   = cin;
        Xa    = a;
        Xb    = b;
        Xc    = c;
        @(posedge Clk);
        #1;
        Start = 1'b0;
    endtask

    // Waits (bounded) for Done, counting Busy cycles and noting any AluKin.
    task automatic wait_done(output int busy_cycles, output bit kin_seen, output bit done_seen);
        busy_cycles = 0;
        kin_seen    = 1'b0;
        done_seen   = 1'b0;
        for (int i = 0; i < 12 && !done_seen; i++) begin
            @(negedge Clk);
            if (Busy) busy_cycles++;
            if (Busy && AluKin) kin_seen = 1'b1;
            if (Done) done_seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        Clr_n = 1'b0;
        Start = 1'b0;
        Op    = 3'd0;
        Cin   = 1'b0;
        Xa    = 16'h0000;
        Xb    = 16'h0000;
        Xc    = 16'h0000;
        #2;
        tests++;
        if ({Busy, Done, Cout, Zero} !== 4'b0000) begin
            fails++;
            $display("[TB] FAIL reset_status: got %b required 0000", {Busy, Done, Cout, Zero});
        end
        tests++;
        if (Result !== 16'h0000) begin
            fails++;
            $display("[TB] FAIL reset_result: got %h required 0000", Result);
        end
        tests++;
        if ({AluA, AluB, AluC, AluAi, AluBi, AluKin, AluM} !== 17'h0) begin
            fails++;
            $display("[TB] FAIL reset_alu_drive: got %h required 0", {AluA, AluB, AluC, AluAi, AluBi, AluKin, AluM});
        end
        @(negedge Clk);
        @(negedge Clk);
        Clr_n = 1'b1;
    endtask

    task automatic test_add_basic();
        int b; bit k; bit d;
        start_op(3'd0, 1'b0, 16'h00FF, 16'h0001, 16'h0000);
        wait_done(b, k, d);
        tests++;
        if (!d) begin fails++; $display("[TB] FAIL add_done: no Done pulse within budget"); end
        tests++;
        if (b != 4) begin fails++; $display("[TB] FAIL add_busy_cycles: got %0d required 4", b); end
        tests++;
        if ({Result, Cout, Zero} !== {16'h0100, 1'b0, 1'b0}) begin
            fails++;
            $display("[TB] FAIL add_result: got %h/%b/%b required 0100/0/0", Result, Cout, Zero);
        end
        @(negedge Clk);
        tests++;
        if ({Done, Busy} !== 2'b00) begin
            fails++;
            $display("[TB] FAIL add_done_width: Done/Busy got %b required 00", {Done, Busy});
        end
        tests++;
        if (Result !== 16'h0100) begin
            fails++;
            $display("[TB] FAIL add_result_hold: got %h required 0100", Result);
        end
    endtask

    task automatic test_arith_directed();
        logic [2:0]  t_op  [4] = '{3'd0, 3'd2, 3'd3, 3'd1};
        logic        t_cin [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [15:0] t_a   [4] = '{16'hFFFF, 16'h0000, 16'h1000, 16'h0001};
        logic [15:0] t_b   [4] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001};
        logic [15:0] t_res [4] = '{16'h0000, 16'hFFFF, 16'h0FFE, 16'h0003};
        logic        t_co  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic        t_z   [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        int b; bit k; bit d;
        for (int i = 0; i < 4; i++) begin
            start_op(t_op[i], t_cin[i], t_a[i], t_b[i], 16'h0000);
            wait_done(b, k, d);
            tests++;
            if (!d || {Result, Cout, Zero} !== {t_res[i], t_co[i], t_z[i]}) begin
                fails++;
                $display("[TB] FAIL arith_%0d: done=%b got %h/%b/%b required %h/%b/%b",
                         i, d, Result, Cout, Zero, t_res[i], t_co[i], t_z[i]);
            end
        end
    endtask

    task automatic test_logic();
        logic [2:0]  t_op  [4] = '{3'd4, 3'd5, 3'd6, 3'd7};
        logic [15:0] t_a   [4] = '{16'hF0F0, 16'hF0F0, 16'hFFFF, 16'h1234};
        logic [15:0] t_b   [4] = '{16'h3C3C, 16'h3C3C, 16'h00FF, 16'h5678};
        logic [15:0] t_c   [4] = '{16'h0000, 16'h0000, 16'h0000, 16'hA5A5};
        logic [15:0] t_res [4] = '{16'h3030, 16'hFCFC, 16'hFF00, 16'hA5A5};
        int b; bit k; bit d;
        for (int i = 0; i < 4; i++) begin
            start_op(t_op[i], 1'b1, t_a[i], t_b[i], t_c[i]);
            wait_done(b, k, d);
            tests++;
            if (!d || Result !== t_res[i] || Cout !== 1'b0) begin
                fails++;
                $display("[TB] FAIL logic_%0d: done=%b got %h/%b required %h/0", i, d, Result, Cout, t_res[i]);
            end
            tests++;
            if (k) begin
                fails++;
                $display("[TB] FAIL logic_kin_%0d: AluKin got 1 required 0", i);
            end
        end
        @(negedge Clk);
        tests++;
        if ({AluA, AluB, AluC, AluAi, AluBi, AluKin, AluM} !== 17'h0) begin
            fails++;
            $display("[TB] FAIL idle_alu_drive: got %h required 0", {AluA, AluB, AluC, AluAi, AluBi, AluKin, AluM});
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic        cin;
        logic [15:0] a, b, c;
        logic [16:0] e;
        int bc; bit k; bit d;
        for (int i = 0; i < 24; i++) begin
            op  = 3'($urandom_range(0, 7));
            cin = 1'($urandom);
            a   = (i % 6 == 0) ? 16'hFFFF : 16'($urandom);
            b   = (i % 7 == 0) ? 16'h0000 : 16'($urandom);
            c   = 16'($urandom);
            e   = ref_op(op, cin, a, b, c);
            start_op(op, cin, a, b, c);
            wait_done(bc, k, d);
            tests++;
            if (!d || {Result, Cout, Zero} !== {e[15:0], e[16], (e[15:0] == 16'h0000)}) begin
                fails++;
                $display("[TB] FAIL random_%0d op=%0d cin=%b a=%h b=%h c=%h: done=%b got %h/%b/%b required %h/%b/%b",
                         i, op, cin, a, b, c, d, Result, Cout, Zero, e[15:0], e[16], (e[15:0] == 16'h0000));
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [16:0] e;
        int b; bit k; bit d;
        e = ref_op(3'd0, 1'b0, 16'h4321, 16'h1111, 16'h0000);
        start_op(3'd0, 1'b0, 16'h4321, 16'h1111, 16'h0000);
        @(negedge Clk);
        Start = 1'b1;
        Op    = 3'd7;
        Xa    = 16'hDEAD;
        Xb    = 16'hBEEF;
        Xc    = 16'hCAFE;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        wait_done(b, k, d);
        tests++;
        if (!d || Result !== e[15:0] || Cout !== e[16]) begin
            fails++;
            $display("[TB] FAIL ignore_start: done=%b got %h/%b required %h/%b", d, Result, Cout, e[15:0], e[16]);
        end
        @(negedge Clk);
        tests++;
        if (Busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL ignore_start_idle: Busy got %b required 0", Busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] e1, e2;
        int b; bit k; bit d;
        int d1, d2;
        e1 = ref_op(3'd2, 1'b0, 16'h8000, 16'h0001, 16'h0000);
        e2 = ref_op(3'd6, 1'b0, 16'h0F0F, 16'hFF00, 16'h0000);
        @(negedge Clk);
        Start = 1'b1;
        Op    = 3'd2;
        Cin   = 1'b0;
        Xa    = 16'h8000;
        Xb    = 16'h0001;
        Xc    = 16'h0000;
        @(posedge Clk);
        #1;
        Op = 3'd6;
        Xa = 16'h0F0F;
        Xb = 16'hFF00;
        wait_done(b, k, d);
        d1 = cyc;
        tests++;
        if (!d || Result !== e1[15:0] || Cout !== e1[16]) begin
            fails++;
            $display("[TB] FAIL b2b_first: done=%b got %h/%b required %h/%b", d, Result, Cout, e1[15:0], e1[16]);
        end
        @(posedge Clk);
        #1;
        Start = 1'b0;
        wait_done(b, k, d);
        d2 = cyc;
        tests++;
        if (!d || Result !== e2[15:0]) begin
            fails++;
            $display("[TB] FAIL b2b_second: done=%b got %h required %h", d, Result, e2[15:0]);
        end
        tests++;
        if (d2 - d1 != 5 || b != 4) begin
            fails++;
            $display("[TB] FAIL b2b_spacing: got %0d cycles busy %0d required 5 cycles busy 4", d2 - d1, b);
        end
    endtask

    task automatic test_reset_abort();
        int b; bit k; bit d;
        bit done_during;
        start_op(3'd0, 1'b0, 16'h5555, 16'h1111, 16'h0000);
        @(posedge Clk);
        @(posedge Clk);
        #3;
        Clr_n = 1'b0;
        #1;
        tests++;
        if ({Busy, Done, Cout, Zero} !== 4'b0000 || Result !== 16'h0000) begin
            fails++;
            $display("[TB] FAIL abort_clear: status %b result %h required 0000/0000", {Busy, Done, Cout, Zero}, Result);
        end
        tests++;
        if ({AluA, AluB, AluC, AluAi, AluBi, AluKin, AluM} !== 17'h0) begin
            fails++;
            $display("[TB] FAIL abort_alu_drive: got %h required 0", {AluA, AluB, AluC, AluAi, AluBi, AluKin, AluM});
        end
        done_during = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            if (Done) done_during = 1'b1;
        end
        Clr_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            if (Done || Busy) done_during = 1'b1;
        end
        tests++;
        if (done_during) begin
            fails++;
            $display("[TB] FAIL abort_no_done: got Done/Busy activity required none");
        end
        start_op(3'd0, 1'b0, 16'h1234, 16'h1111, 16'h0000);
        wait_done(b, k, d);
        tests++;
        if (!d || b != 4 || {Result, Cout, Zero} !== {16'h2345, 1'b0, 1'b0}) begin
            fails++;
            $display("[TB] FAIL abort_next_add: done=%b busy=%0d got %h/%b/%b required 2345/0/0", d, b, Result, Cout, Zero);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_add_basic();
        test_arith_directed();
        test_logic();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
